// File: rtl/reservation_station_if.sv
// reservation_station_if
//   Bundles every non-clock/reset signal of the reservation station.
//   master : dispatch / broadcast / control driver (testbench or decode stage)
//   slave  : the reservation station itself
//   Control : pause, flush
//   Dispatch: op_in, value1_in, value2_in, query1_in, query2_in, imm_in,
//             target_in, is_branch_in
//   Snoop   : alu_num, alu_value, alu_bcast_branch, mem_num, mem_value
//   Status  : rs_full, rs_overflow
//   Issue   : iss_valid, iss_op, iss_a, iss_b, iss_imm, iss_target, iss_is_branch
interface reservation_station_if;
    logic        pause;
    logic        flush;
    logic [4:0]  op_in;
    logic [31:0] value1_in;
    logic [31:0] value2_in;
    logic [2:0]  query1_in;
    logic [2:0]  query2_in;
    logic [31:0] imm_in;
    logic [2:0]  target_in;
    logic        is_branch_in;
    logic [2:0]  alu_num;
    logic [31:0] alu_value;
    logic        alu_bcast_branch;
    logic [2:0]  mem_num;
    logic [31:0] mem_value;
    logic        rs_full;
    logic        rs_overflow;
    logic        iss_valid;
    logic [4:0]  iss_op;
    logic [31:0] iss_a;
    logic [31:0] iss_b;
    logic [31:0] iss_imm;
    logic [2:0]  iss_target;
    logic        iss_is_branch;

    modport master (
        output pause, flush, op_in, value1_in, value2_in, query1_in, query2_in,
               imm_in, target_in, is_branch_in, alu_num, alu_value,
               alu_bcast_branch, mem_num, mem_value,
        input  rs_full, rs_overflow, iss_valid, iss_op, iss_a, iss_b, iss_imm,
               iss_target, iss_is_branch
    );

    modport slave (
        input  pause, flush, op_in, value1_in, value2_in, query1_in, query2_in,
               imm_in, target_in, is_branch_in, alu_num, alu_value,
               alu_bcast_branch, mem_num, mem_value,
        output rs_full, rs_overflow, iss_valid, iss_op, iss_a, iss_b, iss_imm,
               iss_target, iss_is_branch
    );
endinterface

// File: rtl/reservation_station.sv
// reservation_station
//   DEPTH-entry reservation station. Dispatched ops wait for their operand
//   tags to be broadcast by the ALU or memory unit; the lowest-index entry
//   with both operands valid issues each cycle through registered iss_* outputs.
//   clk : clock, all state changes on posedge
//   rst : synchronous active-low reset
//   rs  : reservation_station_if.slave (control, dispatch, snoop, status, issue)
module reservation_station #(
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    reservation_station_if.slave  rs
);
    localparam logic [4:0] OP_NONE = 5'b11111;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic        busy;
        logic [4:0]  op;
        logic [31:0] v1;
        logic [31:0] v2;
        logic [2:0]  q1;
        logic [2:0]  q2;
        logic [31:0] imm;
        logic [2:0]  target;
        logic        is_branch;
    } entry_t;

    typedef struct packed {
        logic [2:0]  q;
        logic [31:0] v;
    } operand_t;

    entry_t ent_q [DEPTH];
    entry_t ent_d [DEPTH];

    logic             alu_hit;
    logic             mem_hit;
    logic             iss_found;
    logic [IDX_W-1:0] iss_idx;
    logic             free_found;
    logic [IDX_W-1:0] free_idx;
    logic             dispatch;
    logic             overflow_set;
    logic [CNT_W-1:0] busy_cnt;
    logic             full_d;
    operand_t         opnd1;
    operand_t         opnd2;

    logic             rs_full_q;
    logic             rs_overflow_q;
    logic             iss_valid_q;
    logic [4:0]       iss_op_q;
    logic [31:0]      iss_a_q;
    logic [31:0]      iss_b_q;
    logic [31:0]      iss_imm_q;
    logic [2:0]       iss_target_q;
    logic             iss_is_branch_q;

    // A branch-outcome ALU broadcast carries no register value.
    assign alu_hit = (rs.alu_num != 3'd0) && !rs.alu_bcast_branch;
    assign mem_hit = (rs.mem_num != 3'd0);

    // Resolve one operand against this cycle's broadcasts; memory wins a tie.
    function automatic operand_t snoop(input logic [2:0] q, input logic [31:0] v);
        operand_t r;
        r.q = q;
        r.v = v;
        if (q != 3'd0) begin
            if (mem_hit && q == rs.mem_num) begin
                r.q = 3'd0;
                r.v = rs.mem_value;
            end else if (alu_hit && q == rs.alu_num) begin
                r.q = 3'd0;
                r.v = rs.alu_value;
            end
        end
        return r;
    endfunction

    always_comb begin
        ent_d        = ent_q;
        opnd1        = '0;
        opnd2        = '0;
        iss_found    = 1'b0;
        iss_idx      = '0;
        free_found   = 1'b0;
        free_idx     = '0;
        busy_cnt     = '0;

        // Ready selection looks only at registered state, so a broadcast
        // never makes its consumer issue in the same cycle.
        for (int i = 0; i < DEPTH; i++) begin
            if (!iss_found && ent_q[i].busy && ent_q[i].q1 == 3'd0 && ent_q[i].q2 == 3'd0) begin
                iss_found = 1'b1;
                iss_idx   = IDX_W'(i);
            end
        end
        if (iss_found) begin
            ent_d[iss_idx].busy = 1'b0;
        end

        for (int i = 0; i < DEPTH; i++) begin
            if (ent_d[i].busy) begin
                opnd1       = snoop(ent_d[i].q1, ent_d[i].v1);
                opnd2       = snoop(ent_d[i].q2, ent_d[i].v2);
                ent_d[i].q1 = opnd1.q;
                ent_d[i].v1 = opnd1.v;
                ent_d[i].q2 = opnd2.q;
                ent_d[i].v2 = opnd2.v;
            end
        end

        // Free search runs after the issue release so the issuing slot can be refilled.
        for (int i = 0; i < DEPTH; i++) begin
            if (!free_found && !ent_d[i].busy) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end

        dispatch     = (rs.op_in != OP_NONE);
        overflow_set = dispatch && !free_found;
        if (dispatch && free_found) begin
            opnd1                     = snoop(rs.query1_in, rs.value1_in);
            opnd2                     = snoop(rs.query2_in, rs.value2_in);
            ent_d[free_idx].busy      = 1'b1;
            ent_d[free_idx].op        = rs.op_in;
            ent_d[free_idx].v1        = opnd1.v;
            ent_d[free_idx].q1        = opnd1.q;
            ent_d[free_idx].v2        = opnd2.v;
            ent_d[free_idx].q2        = opnd2.q;
            ent_d[free_idx].imm       = rs.imm_in;
            ent_d[free_idx].target    = rs.target_in;
            ent_d[free_idx].is_branch = rs.is_branch_in;
        end

        for (int i = 0; i < DEPTH; i++) begin
            busy_cnt = busy_cnt + CNT_W'(ent_d[i].busy);
        end
        // One slot of margin because dispatch sees rs_full a cycle late.
        full_d = (busy_cnt >= CNT_W'(DEPTH - 1));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i].busy <= 1'b0;
                ent_q[i].q1   <= 3'd0;
                ent_q[i].q2   <= 3'd0;
            end
            rs_full_q       <= 1'b0;
            rs_overflow_q   <= 1'b0;
            iss_valid_q     <= 1'b0;
            iss_op_q        <= OP_NONE;
            iss_target_q    <= 3'd0;
            iss_a_q         <= 32'd0;
            iss_b_q         <= 32'd0;
            iss_imm_q       <= 32'd0;
            iss_is_branch_q <= 1'b0;
        end else if (rs.pause) begin
            // Operand data holds; op/target follow the idle encoding so they
            // never disagree with iss_valid = 0.
            iss_valid_q  <= 1'b0;
            iss_op_q     <= OP_NONE;
            iss_target_q <= 3'd0;
        end else if (rs.flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i].busy <= 1'b0;
            end
            rs_full_q    <= 1'b0;
            iss_valid_q  <= 1'b0;
            iss_op_q     <= OP_NONE;
            iss_target_q <= 3'd0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= ent_d[i];
            end
            rs_full_q     <= full_d;
            rs_overflow_q <= rs_overflow_q | overflow_set;
            iss_valid_q   <= iss_found;
            if (iss_found) begin
                iss_op_q        <= ent_q[iss_idx].op;
                iss_a_q         <= ent_q[iss_idx].v1;
                iss_b_q         <= ent_q[iss_idx].v2;
                iss_imm_q       <= ent_q[iss_idx].imm;
                iss_target_q    <= ent_q[iss_idx].target;
                iss_is_branch_q <= ent_q[iss_idx].is_branch;
            end else begin
                iss_op_q     <= OP_NONE;
                iss_target_q <= 3'd0;
            end
        end
    end

    assign rs.rs_full       = rs_full_q;
    assign rs.rs_overflow   = rs_overflow_q;
    assign rs.iss_valid     = iss_valid_q;
    assign rs.iss_op        = iss_op_q;
    assign rs.iss_a         = iss_a_q;
    assign rs.iss_b         = iss_b_q;
    assign rs.iss_imm       = iss_imm_q;
    assign rs.iss_target    = iss_target_q;
    assign rs.iss_is_branch = iss_is_branch_q;
endmodule

// File: tb/tb_reservation_station.sv
// tb_reservation_station
//   Self-checking bench: a behavioural model tracks the station every cycle,
//   a vector table covers single-op cases, hand sequences cover multi-cycle
//   corners, and a randomized phase stresses everything against the model.
module tb_reservation_station;
    localparam logic [4:0] NOP = 5'b11111;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    reservation_station_if rif();
    reservation_station #(.DEPTH(4)) dut (.clk(clk), .rst(rst), .rs(rif.slave));

    int checks = 0;
    int errors = 0;

    // ---------------- behavioural model ----------------
    typedef struct {
        bit          busy;
        logic [4:0]  op;
        logic [31:0] v1, v2, imm;
        logic [2:0]  q1, q2, tgt;
        bit          br;
    } slot_t;

    slot_t       m [4];
    bit          m_full, m_ovf, m_iv, m_br;
    logic [4:0]  m_op;
    logic [31:0] m_a, m_b, m_imm;
    logic [2:0]  m_tgt;

    // Value broadcast this cycle for a tag, if any (memory has priority).
    function automatic bit bcast(input logic [2:0] tag, output logic [31:0] val);
        val = 32'd0;
        if (tag == 3'd0) return 1'b0;
        if (rif.mem_num == tag) begin val = rif.mem_value; return 1'b1; end
        if (rif.alu_num == tag && !rif.alu_bcast_branch) begin val = rif.alu_value; return 1'b1; end
        return 1'b0;
    endfunction

    task automatic model_step();
        int sel, fre, cnt;
        bit hit;
        logic [31:0] bv;
        if (!rst) begin
            foreach (m[i]) begin m[i].busy = 0; m[i].q1 = 0; m[i].q2 = 0; end
            m_full = 0; m_ovf = 0; m_iv = 0; m_op = NOP; m_tgt = 0;
            m_a = 0; m_b = 0; m_imm = 0; m_br = 0;
        end else if (rif.pause) begin
            m_iv = 0; m_op = NOP; m_tgt = 0;
        end else if (rif.flush) begin
            foreach (m[i]) m[i].busy = 0;
            m_full = 0; m_iv = 0; m_op = NOP; m_tgt = 0;
        end else begin
            sel = -1;
            foreach (m[i]) if (sel < 0 && m[i].busy && m[i].q1 == 0 && m[i].q2 == 0) sel = i;
            m_iv = (sel >= 0);
            if (sel >= 0) begin
                m_op = m[sel].op; m_a = m[sel].v1; m_b = m[sel].v2; m_imm = m[sel].imm;
                m_tgt = m[sel].tgt; m_br = m[sel].br; m[sel].busy = 0;
            end else begin
                m_op = NOP; m_tgt = 0;
            end
            foreach (m[i]) begin
                if (m[i].busy) begin
                    hit = bcast(m[i].q1, bv); if (hit) begin m[i].q1 = 0; m[i].v1 = bv; end
                    hit = bcast(m[i].q2, bv); if (hit) begin m[i].q2 = 0; m[i].v2 = bv; end
                end
            end
            if (rif.op_in != NOP) begin
                fre = -1;
                foreach (m[i]) if (fre < 0 && !m[i].busy) fre = i;
                if (fre < 0) m_ovf = 1;
                else begin
                    m[fre].busy = 1; m[fre].op = rif.op_in; m[fre].imm = rif.imm_in;
                    m[fre].tgt = rif.target_in; m[fre].br = rif.is_branch_in;
                    m[fre].v1 = rif.value1_in; m[fre].q1 = rif.query1_in;
                    m[fre].v2 = rif.value2_in; m[fre].q2 = rif.query2_in;
                    hit = bcast(m[fre].q1, bv); if (hit) begin m[fre].q1 = 0; m[fre].v1 = bv; end
                    hit = bcast(m[fre].q2, bv); if (hit) begin m[fre].q2 = 0; m[fre].v2 = bv; end
                end
            end
            cnt = 0;
            foreach (m[i]) cnt += int'(m[i].busy);
            m_full = (cnt >= 3);
        end
    endtask

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        chk("rs_full", 32'(rif.rs_full), 32'(m_full));
        chk("rs_overflow", 32'(rif.rs_overflow), 32'(m_ovf));
        chk("iss_valid", 32'(rif.iss_valid), 32'(m_iv));
        chk("iss_op", 32'(rif.iss_op), 32'(m_op));
        chk("iss_target", 32'(rif.iss_target), 32'(m_tgt));
        if (m_iv) begin
            chk("iss_a", rif.iss_a, m_a);
            chk("iss_b", rif.iss_b, m_b);
            chk("iss_imm", rif.iss_imm, m_imm);
            chk("iss_is_branch", 32'(rif.iss_is_branch), 32'(m_br));
        end
    endtask

    task automatic idle_inputs();
        rif.pause = 0; rif.flush = 0; rif.op_in = NOP;
        rif.value1_in = 0; rif.value2_in = 0; rif.query1_in = 0; rif.query2_in = 0;
        rif.imm_in = 0; rif.target_in = 3'd1; rif.is_branch_in = 0;
        rif.alu_num = 0; rif.alu_value = 0; rif.alu_bcast_branch = 0;
        rif.mem_num = 0; rif.mem_value = 0;
    endtask

    task automatic disp(input logic [4:0] op, input logic [31:0] v1, input logic [31:0] v2,
                        input logic [2:0] q1, input logic [2:0] q2, input logic [2:0] tgt);
        rif.op_in = op; rif.value1_in = v1; rif.value2_in = v2;
        rif.query1_in = q1; rif.query2_in = q2; rif.target_in = tgt;
    endtask

    function automatic logic [2:0] rtag();
        return ($urandom_range(2) == 0) ? 3'd0 : 3'($urandom_range(7, 1));
    endfunction

    // ---------------- vector table ----------------
    typedef struct {
        logic [4:0]  op;
        logic [31:0] v1, v2;
        logic [2:0]  q1, q2;
        logic [31:0] imm;
        logic [2:0]  tgt;
        bit          br;
        logic [2:0]  an;
        logic [31:0] av;
        bit          ab;
        logic [2:0]  mn;
        logic [31:0] mv;
        bit          ev;
        logic [31:0] ea, eb, eimm;
        logic [2:0]  etgt;
    } vec_t;

    vec_t vt [8];

    initial begin
        vt[0] = '{5'd0, 32'd5, 32'd7, 3'd0, 3'd0, 32'd0, 3'd3, 1'b0, 3'd0, 32'd0, 1'b0, 3'd0, 32'd0,
                  1'b1, 32'd5, 32'd7, 32'd0, 3'd3};
        vt[1] = '{5'd2, 32'd1, 32'd0, 3'd0, 3'd6, 32'd0, 3'd5, 1'b0, 3'd0, 32'd0, 1'b0, 3'd6, 32'hAB,
                  1'b1, 32'd1, 32'hAB, 32'd0, 3'd5};
        vt[2] = '{5'd3, 32'd0, 32'd2, 3'd4, 3'd0, 32'd0, 3'd1, 1'b0, 3'd4, 32'h10, 1'b0, 3'd0, 32'd0,
                  1'b1, 32'h10, 32'd2, 32'd0, 3'd1};
        vt[3] = '{5'd3, 32'd0, 32'd2, 3'd4, 3'd0, 32'd0, 3'd1, 1'b0, 3'd4, 32'h10, 1'b1, 3'd0, 32'd0,
                  1'b0, 32'd0, 32'd0, 32'd0, 3'd0};
        vt[4] = '{5'd4, 32'd0, 32'd0, 3'd2, 3'd2, 32'd0, 3'd7, 1'b0, 3'd2, 32'h55, 1'b0, 3'd2, 32'h66,
                  1'b1, 32'h66, 32'h66, 32'd0, 3'd7};
        vt[5] = '{5'd1, 32'd9, 32'd9, 3'd3, 3'd0, 32'd0, 3'd4, 1'b0, 3'd0, 32'd0, 1'b0, 3'd5, 32'h77,
                  1'b0, 32'd0, 32'd0, 32'd0, 3'd0};
        vt[6] = '{NOP, 32'd1, 32'd2, 3'd0, 3'd0, 32'd0, 3'd2, 1'b0, 3'd0, 32'd0, 1'b0, 3'd0, 32'd0,
                  1'b0, 32'd0, 32'd0, 32'd0, 3'd0};
        vt[7] = '{5'd6, 32'hFFFF_FFFF, 32'd0, 3'd0, 3'd0, 32'h1234, 3'd2, 1'b1, 3'd0, 32'd0, 1'b0, 3'd0, 32'd0,
                  1'b1, 32'hFFFF_FFFF, 32'd0, 32'h1234, 3'd2};

        // ---- reset ----
        idle_inputs();
        rst = 0;
        tick(); tick();
        chk("rst_iss_valid", 32'(rif.iss_valid), 32'd0);
        chk("rst_iss_op", 32'(rif.iss_op), 32'h1F);
        chk("rst_iss_target", 32'(rif.iss_target), 32'd0);
        chk("rst_iss_a", rif.iss_a, 32'd0);
        chk("rst_iss_b", rif.iss_b, 32'd0);
        chk("rst_iss_imm", rif.iss_imm, 32'd0);
        chk("rst_iss_is_branch", 32'(rif.iss_is_branch), 32'd0);
        chk("rst_rs_full", 32'(rif.rs_full), 32'd0);
        chk("rst_rs_overflow", 32'(rif.rs_overflow), 32'd0);
        rst = 1;

        // ---- table: dispatch, one idle cycle, then observe the issue slot ----
        for (int k = 0; k < 8; k++) begin
            idle_inputs();
            disp(vt[k].op, vt[k].v1, vt[k].v2, vt[k].q1, vt[k].q2, vt[k].tgt);
            rif.imm_in = vt[k].imm; rif.is_branch_in = vt[k].br;
            rif.alu_num = vt[k].an; rif.alu_value = vt[k].av; rif.alu_bcast_branch = vt[k].ab;
            rif.mem_num = vt[k].mn; rif.mem_value = vt[k].mv;
            tick();
            idle_inputs();
            tick();
            chk($sformatf("vec%0d_valid", k), 32'(rif.iss_valid), 32'(vt[k].ev));
            if (vt[k].ev) begin
                chk($sformatf("vec%0d_a", k), rif.iss_a, vt[k].ea);
                chk($sformatf("vec%0d_b", k), rif.iss_b, vt[k].eb);
                chk($sformatf("vec%0d_imm", k), rif.iss_imm, vt[k].eimm);
                chk($sformatf("vec%0d_tgt", k), 32'(rif.iss_target), 32'(vt[k].etgt));
                chk($sformatf("vec%0d_br", k), 32'(rif.iss_is_branch), 32'(vt[k].br));
            end
            rif.flush = 1; tick(); rif.flush = 0;
        end

        // ---- wakeup by a later ALU broadcast; branch broadcast does not wake ----
        idle_inputs(); disp(5'd0, 32'd0, 32'd8, 3'd4, 3'd0, 3'd2); tick();
        idle_inputs(); rif.alu_num = 3'd4; rif.alu_value = 32'h10; tick();
        chk("wake_same_edge_valid", 32'(rif.iss_valid), 32'd0);
        idle_inputs(); tick();
        chk("wake_valid", 32'(rif.iss_valid), 32'd1);
        chk("wake_a", rif.iss_a, 32'h10);
        disp(5'd0, 32'd0, 32'd8, 3'd4, 3'd0, 3'd2); tick();
        idle_inputs(); rif.alu_num = 3'd4; rif.alu_value = 32'h10; rif.alu_bcast_branch = 1; tick();
        idle_inputs(); tick(); tick();
        chk("branch_bcast_no_wake", 32'(rif.iss_valid), 32'd0);
        rif.flush = 1; tick(); rif.flush = 0;

        // ---- fill, overflow, drain in slot order ----
        for (int k = 0; k < 4; k++) begin
            disp(5'd1, 32'd0, 32'd0, 3'd7, 3'd0, 3'(k + 1)); tick();
            chk($sformatf("fill%0d_full", k), 32'(rif.rs_full), (k >= 2) ? 32'd1 : 32'd0);
        end
        disp(5'd1, 32'd0, 32'd0, 3'd7, 3'd0, 3'd5); tick();
        chk("overflow_set", 32'(rif.rs_overflow), 32'd1);
        idle_inputs(); rif.alu_num = 3'd7; rif.alu_value = 32'h77; tick();
        idle_inputs();
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("drain%0d_valid", k), 32'(rif.iss_valid), 32'd1);
            chk($sformatf("drain%0d_tgt", k), 32'(rif.iss_target), 32'(k + 1));
        end
        tick();
        chk("drain_done", 32'(rif.iss_valid), 32'd0);

        // ---- pause holds a ready entry; flush empties the station ----
        disp(5'd2, 32'h11, 32'h22, 3'd0, 3'd0, 3'd6); tick();
        idle_inputs(); rif.pause = 1;
        disp(5'd2, 32'h33, 32'h44, 3'd0, 3'd0, 3'd7);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("pause_valid", 32'(rif.iss_valid), 32'd0);
        end
        idle_inputs(); tick();
        chk("unpause_valid", 32'(rif.iss_valid), 32'd1);
        chk("unpause_tgt", 32'(rif.iss_target), 32'd6);
        tick();
        chk("pause_dispatch_ignored", 32'(rif.iss_valid), 32'd0);
        for (int k = 0; k < 3; k++) begin disp(5'd1, 32'd0, 32'd0, 3'd7, 3'd0, 3'(k + 1)); tick(); end
        chk("pre_flush_full", 32'(rif.rs_full), 32'd1);
        disp(5'd1, 32'd1, 32'd1, 3'd0, 3'd0, 3'd4); rif.flush = 1; tick();
        chk("flush_full", 32'(rif.rs_full), 32'd0);
        chk("flush_valid", 32'(rif.iss_valid), 32'd0);
        idle_inputs(); tick();
        chk("flush_dispatch_ignored", 32'(rif.iss_valid), 32'd0);
        rif.alu_num = 3'd7; tick(); idle_inputs(); tick();
        chk("flush_no_late_issue", 32'(rif.iss_valid), 32'd0);

        // ---- reset mid-operation ----
        disp(5'd1, 32'd0, 32'd0, 3'd5, 3'd0, 3'd1); tick();
        disp(5'd1, 32'd0, 32'd0, 3'd5, 3'd0, 3'd2); tick();
        disp(5'd1, 32'd3, 32'd4, 3'd0, 3'd0, 3'd3); tick();
        idle_inputs(); rst = 0; tick();
        chk("midrst_valid", 32'(rif.iss_valid), 32'd0);
        chk("midrst_full", 32'(rif.rs_full), 32'd0);
        chk("midrst_overflow", 32'(rif.rs_overflow), 32'd0);
        chk("midrst_tgt", 32'(rif.iss_target), 32'd0);
        rst = 1; rif.alu_num = 3'd5; rif.alu_value = 32'h5; tick();
        idle_inputs(); tick();
        chk("midrst_no_issue", 32'(rif.iss_valid), 32'd0);

        // ---- randomized traffic against the model ----
        for (int n = 0; n < 1500; n++) begin
            rif.op_in = ($urandom_range(3) == 0) ? NOP : 5'($urandom_range(30));
            rif.value1_in = $urandom(); rif.value2_in = $urandom(); rif.imm_in = $urandom();
            rif.query1_in = rtag(); rif.query2_in = rtag();
            rif.target_in = 3'($urandom_range(7, 1)); rif.is_branch_in = 1'($urandom_range(1));
            rif.alu_num = ($urandom_range(1) == 0) ? 3'd0 : 3'($urandom_range(7, 1));
            rif.alu_value = $urandom(); rif.alu_bcast_branch = ($urandom_range(3) == 0);
            rif.mem_num = ($urandom_range(1) == 0) ? 3'd0 : 3'($urandom_range(7, 1));
            rif.mem_value = $urandom();
            rif.pause = ($urandom_range(15) == 0);
            rif.flush = ($urandom_range(31) == 0);
            rst = ($urandom_range(199) != 0);
            tick();
        end
        rst = 1; idle_inputs(); tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
